// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter and its helpers.
// Holds the FSM state encoding, grant identifiers and default widths/constants.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Loadable down-counter with clear and enable; expired is high while the count is zero.
// Generic enough to serve as the core of a timer peripheral as well.
module arb_timeout_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Clear beats load, load beats counting; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the mem-stage data path,
// running one req/ack transaction at a time with alternating priority and a timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    TIMEOUT_CYC = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_INST    = DATA_WIDTH'(DEF_NOP_INST)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_ce_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_inst_o,
    output logic                  if_valid_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_done_o,
    output logic                  stallreq_o,
    output logic                  err_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  ram_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t state;
    arb_state_t next_state;
    grant_t     last_grant;

    logic fetch_pend;
    logic data_pend;
    logic grant_fetch;
    logic grant_data;
    logic finish;
    logic timed_out;
    logic in_flight;
    logic flushed;
    logic requester_live;
    logic cnt_expired;

    // A requester whose completion pulse is showing this cycle is not asking again yet.
    assign fetch_pend = if_ce_i & ~if_valid_o;
    assign data_pend  = d_req_i & ~d_done_o;
    assign in_flight  = (state == ARB_FETCH) || (state == ARB_DATA);

    assign requester_live = ~flushed & ((state == ARB_FETCH) ? if_ce_i : d_req_i);

    assign stallreq_o = (d_req_i & ~d_done_o) | (if_ce_i & ~if_valid_o);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Data wins a tie unless it won the previous grant, so neither side can starve.
    always_comb begin
        next_state  = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        finish      = 1'b0;
        timed_out   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (fetch_pend && data_pend) begin
                    if (last_grant == GRANT_DATA) begin
                        grant_fetch = 1'b1;
                    end else begin
                        grant_data = 1'b1;
                    end
                end else if (data_pend) begin
                    grant_data = 1'b1;
                end else if (fetch_pend) begin
                    grant_fetch = 1'b1;
                end
                if (grant_fetch) begin
                    next_state = ARB_FETCH;
                end else if (grant_data) begin
                    next_state = ARB_DATA;
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (ram_ack_i) begin
                    finish     = 1'b1;
                    next_state = ARB_IDLE;
                end else if (cnt_expired) begin
                    timed_out  = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    arb_timeout_cnt #(
        .WIDTH(CNT_W)
    ) u_timeout_cnt (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .clear     (finish | timed_out),
        .load      (grant_fetch | grant_data),
        .load_value(CNT_LOAD),
        .enable    (in_flight),
        .expired   (cnt_expired)
    );

    // RAM-side outputs are registered and held for the whole transaction; a flushed
    // requester still lets the RAM finish but its result is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_inst_o   <= '0;
            if_valid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_done_o    <= 1'b0;
            err_o       <= 1'b0;
            last_grant  <= GRANT_FETCH;
            flushed     <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            d_done_o   <= 1'b0;
            err_o      <= 1'b0;
            if (grant_fetch) begin
                ram_req_o   <= 1'b1;
                ram_we_o    <= 1'b0;
                ram_addr_o  <= if_addr_i;
                ram_wdata_o <= '0;
                last_grant  <= GRANT_FETCH;
                flushed     <= 1'b0;
            end else if (grant_data) begin
                ram_req_o   <= 1'b1;
                ram_we_o    <= d_we_i;
                ram_addr_o  <= d_addr_i;
                ram_wdata_o <= d_wdata_i;
                last_grant  <= GRANT_DATA;
                flushed     <= 1'b0;
            end else if (finish || timed_out) begin
                ram_req_o <= 1'b0;
                ram_we_o  <= 1'b0;
                err_o     <= timed_out;
                if (requester_live) begin
                    if (state == ARB_FETCH) begin
                        if_valid_o <= 1'b1;
                        if_inst_o  <= timed_out ? NOP_INST : ram_rdata_i;
                    end else begin
                        d_done_o  <= 1'b1;
                        d_rdata_o <= timed_out ? '0 : ram_rdata_i;
                    end
                end
            end else if (in_flight && !requester_live) begin
                flushed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie-break order, store, flush,
// timeout, spurious ack and asynchronous reset, with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        stallreq_o;
    logic        err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_ack_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT_CYC(8),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_ce_i    (if_ce_i),
        .if_addr_i  (if_addr_i),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_rdata_o  (d_rdata_o),
        .d_done_o   (d_done_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .ram_req_o  (ram_req_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .ram_ack_i  (ram_ack_i)
    );

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic ce, input logic [31:0] ia, input logic dr,
                                 input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                                 input logic ack, input logic [31:0] rd);
        if_ce_i     = ce;
        if_addr_i   = ia;
        d_req_i     = dr;
        d_we_i      = dwe;
        d_addr_i    = da;
        d_wdata_i   = dwd;
        ram_ack_i   = ack;
        ram_rdata_i = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #20;
        checkOutput("rst_ram_req", ram_req_o, 0);
        checkOutput("rst_if_valid", if_valid_o, 0);
        checkOutput("rst_d_done", d_done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_if_inst", if_inst_o, 0);
        checkOutput("rst_d_rdata", d_rdata_o, 0);
        checkOutput("rst_stall", stallreq_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fetch only: ack on the third ram_req_o cycle, completion one cycle later.
        nextCycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("f_c0_stall", stallreq_o, 1);
        checkOutput("f_c0_req", ram_req_o, 0);
        nextCycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("f_c1_req", ram_req_o, 1);
        checkOutput("f_c1_addr", ram_addr_o, 32'h100);
        checkOutput("f_c1_we", ram_we_o, 0);
        nextCycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("f_c2_req", ram_req_o, 1);
        checkOutput("f_c2_stall", stallreq_o, 1);
        nextCycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h0050_0093);
        checkOutput("f_c3_req", ram_req_o, 1);
        checkOutput("f_c3_valid", if_valid_o, 0);
        nextCycle();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("f_c4_valid", if_valid_o, 1);
        checkOutput("f_c4_inst", if_inst_o, 32'h0050_0093);
        checkOutput("f_c4_req", ram_req_o, 0);
        checkOutput("f_c4_stall", stallreq_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("f_c5_valid", if_valid_o, 0);
        checkOutput("f_c5_req", ram_req_o, 0);

        // Both requesters pending: order must be D, F, D, F with single-cycle acks.
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        checkOutput("s_c0_req", ram_req_o, 0);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'h1111_1111);
        checkOutput("s_c1_addr_d", ram_addr_o, 32'h2000);
        checkOutput("s_c1_req", ram_req_o, 1);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        checkOutput("s_c2_done", d_done_o, 1);
        checkOutput("s_c2_rdata", d_rdata_o, 32'h1111_1111);
        checkOutput("s_c2_req_gap", ram_req_o, 0);
        checkOutput("s_c2_stall", stallreq_o, 1);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'h2222_2222);
        checkOutput("s_c3_addr_f", ram_addr_o, 32'h104);
        checkOutput("s_c3_done", d_done_o, 0);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        checkOutput("s_c4_valid", if_valid_o, 1);
        checkOutput("s_c4_inst", if_inst_o, 32'h2222_2222);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'h3333_3333);
        checkOutput("s_c5_addr_d", ram_addr_o, 32'h2000);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        checkOutput("s_c6_done", d_done_o, 1);
        checkOutput("s_c6_rdata", d_rdata_o, 32'h3333_3333);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'h4444_4444);
        checkOutput("s_c7_addr_f", ram_addr_o, 32'h104);
        nextCycle();
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0);
        checkOutput("s_c8_valid", if_valid_o, 1);
        checkOutput("s_c8_inst", if_inst_o, 32'h4444_4444);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("s_c9_req", ram_req_o, 0);

        // Store: write strobe and data held until ack; only d_done_o pulses.
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 0, 0);
        checkOutput("w_c1_we", ram_we_o, 1);
        checkOutput("w_c1_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        checkOutput("w_c1_addr", ram_addr_o, 32'h2004);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 1, 32'h0000_0055);
        checkOutput("w_c2_we", ram_we_o, 1);
        checkOutput("w_c2_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 0, 0);
        checkOutput("w_c3_done", d_done_o, 1);
        checkOutput("w_c3_if_valid", if_valid_o, 0);
        checkOutput("w_c3_req", ram_req_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("w_c4_done", d_done_o, 0);

        // Flush: fetch withdrawn mid-flight, RAM still completes, no valid pulse.
        nextCycle();
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c1_req", ram_req_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c2_req", ram_req_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_AAAA);
        checkOutput("fl_c3_req", ram_req_o, 1);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h2008, 0, 0, 0);
        checkOutput("fl_c4_valid", if_valid_o, 0);
        checkOutput("fl_c4_req", ram_req_o, 0);
        checkOutput("fl_c4_inst", if_inst_o, 32'h4444_4444);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h2008, 0, 1, 32'h0000_0066);
        checkOutput("fl_c5_addr", ram_addr_o, 32'h2008);
        checkOutput("fl_c5_req", ram_req_o, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c6_done", d_done_o, 1);
        checkOutput("fl_c6_rdata", d_rdata_o, 32'h0000_0066);

        // Timeout after 8 un-acked cycles: NOP returned to fetch plus an err_o pulse.
        nextCycle();
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            nextCycle();
            applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("to_c%0d_req", c), ram_req_o, 1);
            checkOutput($sformatf("to_c%0d_err", c), err_o, 0);
        end
        nextCycle();
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
        checkOutput("to_c9_req", ram_req_o, 0);
        checkOutput("to_c9_err", err_o, 1);
        checkOutput("to_c9_valid", if_valid_o, 1);
        checkOutput("to_c9_inst", if_inst_o, 32'h0000_0013);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("to_c10_err", err_o, 0);

        // Spurious ack while idle must not produce any completion.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBBBB_BBBB);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sp_valid", if_valid_o, 0);
        checkOutput("sp_done", d_done_o, 0);
        checkOutput("sp_req", ram_req_o, 0);

        // Asynchronous reset in the middle of a data transaction.
        applyStimulus(0, 0, 1, 0, 32'h2010, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h2010, 0, 0, 0);
        checkOutput("ar_req_before", ram_req_o, 1);
        rst_i = 1'b0;
        #1;
        checkOutput("ar_req_async", ram_req_o, 0);
        checkOutput("ar_done_async", d_done_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ar_stall", stallreq_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h2010, 0, 0, 0);
        checkOutput("ar_post_idle", ram_req_o, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h2010, 0, 1, 32'h0000_0077);
        checkOutput("ar_post_req", ram_req_o, 1);
        checkOutput("ar_post_addr", ram_addr_o, 32'h2010);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ar_post_done", d_done_o, 1);
        checkOutput("ar_post_rdata", d_rdata_o, 32'h0000_0077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single RAM port between the instruction-fetch path (pc_reg/if_id) and the mem-stage data path.
- Sequences one RAM transaction at a time over a req/ack handshake with variable latency.
- Returns fetched instructions and load data to the pipeline.
- Raises a stall request to pipe_ctrl while either requester is waiting.
- Sits between core_top's fetch/data ports and the RAM.

Parameters:
ADDR_WIDTH, 32, address width of both requesters and RAM
DATA_WIDTH, 32, data/instruction width
TIMEOUT_CYC, 64, max cycles waiting for ram_ack_i before abort (>=2)
NOP_INST, 32'h00000013, instruction returned to fetch on timeout

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-low
if_ce_i  in  1  fetch request (level, held until if_valid_o)
if_addr_i  in  ADDR_WIDTH  fetch address
if_inst_o  out  DATA_WIDTH  fetched instruction, valid with if_valid_o
if_valid_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request (level, held until d_done_o)
d_we_i  in  1  1=store, 0=load
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  store data
d_rdata_o  out  DATA_WIDTH  load data, valid with d_done_o
d_done_o  out  1  one-cycle data completion pulse
stallreq_o  out  1  stall request to pipe_ctrl
err_o  out  1  one-cycle pulse on timeout abort
ram_req_o  out  1  RAM request, held until ack
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid with ram_ack_i
ram_ack_i  in  1  RAM completion, single-cycle pulse

Behaviour:
- Reset (rst_i=0, async): state=IDLE, all outputs 0, if_inst_o=0, d_rdata_o=0, last_grant=FETCH, timeout counter=0.
- States:
  - IDLE: no RAM transaction outstanding.
  - FETCH: fetch transaction in flight.
  - DATA: data transaction in flight.
- Grant in IDLE:
  - Both pending: data wins, unless last_grant=DATA and if_ce_i is pending, in which case fetch wins. This alternates and prevents starvation.
  - Single pending request: granted.
  - A requester whose done/valid pulse is high this cycle is not re-granted this cycle.
- On grant: latch addr/we/wdata. Next cycle ram_req_o=1 with the latched values (registered outputs). Fetch always drives ram_we_o=0. Update last_grant.
- FETCH/DATA: hold ram_req_o and latched values stable until ram_ack_i=1.
  - On ack, register ram_rdata_i into if_inst_o or d_rdata_o and pulse the matching if_valid_o/d_done_o for 1 cycle.
  - In the same edge: ram_req_o=0, state goes to IDLE.
- Latency: request seen in IDLE at cycle 0, ram_req_o=1 at cycle 1, ack at cycle k (k>=1), completion pulse at cycle k+1. Minimum is 2 cycles.
- No back-to-back RAM requests: ram_req_o is low for at least one cycle between transactions.
- Store: d_done_o pulses on ack; d_rdata_o holds the value captured from ram_rdata_i (don't-care for software).
- Requester withdraws mid-transaction (flush: if_ce_i/d_req_i drops): the transaction still completes on RAM. The result is discarded; no valid/done pulse.
- Timeout: counter counts cycles in FETCH/DATA and resets on state entry. At TIMEOUT_CYC without ack:
  - drop ram_req_o, pulse err_o, return to IDLE;
  - fetch completes with if_inst_o=NOP_INST and if_valid_o=1;
  - data completes with d_rdata_o=0 and d_done_o=1.
- Ack in IDLE (spurious) is ignored.
- stallreq_o (combinational) = (d_req_i & ~d_done_o) | (if_ce_i & ~if_valid_o).
- Reset mid-transaction: immediate return to IDLE, ram_req_o drops asynchronously, no pulses.

Decomposition:
- Shared defines file (defines.v): ADDR_WIDTH/DATA_WIDTH macros, state encodings (ARB_IDLE=2'd0, ARB_FETCH=2'd1, ARB_DATA=2'd2), NOP_INST constant.
- One natural sub-module: arb_timeout_cnt. Loadable down-counter with clear/enable and an expired flag, reused later by the timer peripheral.

Test Plan:
- Fetch only: if_ce_i=1, addr=0x100, RAM acks 3 cycles after ram_req_o with 0x00500093 -> ram_req_o high cycles 1-3 with ram_addr_o=0x100, we=0; if_valid_o pulses cycle 4 with if_inst_o=0x00500093; stallreq_o high cycles 0-3.
- Simultaneous requests: if_ce_i and d_req_i (load 0x2000) both asserted at cycle 0, single-cycle acks -> data served first (d_done_o with data), then fetch granted next; order D,F,D,F when both stay pending.
- Store: d_we_i=1, addr=0x2004, wdata=0xDEADBEEF -> ram_we_o=1, ram_wdata_o=0xDEADBEEF stable until ack; d_done_o one pulse; if_valid_o never pulses.
- Flush: drop if_ce_i two cycles after grant, then ack -> no if_valid_o pulse; ram_req_o falls after ack; next request granted normally.
- Timeout: TIMEOUT_CYC=8, never ack a fetch -> after 8 cycles ram_req_o=0, err_o pulse, if_valid_o=1 with 0x00000013.
- Reset: assert rst_i=0 mid-DATA -> ram_req_o, d_done_o and stallreq_o-driving state clear immediately without waiting for clk_i; after release, a first request completes normally.
